// File: rtl/zero_bist.sv
// Built-in self test for an 8-bit zero detector: walks a fixed pattern table and counts flag mismatches.
// Optional first-failure capture (fail_pattern port) is enabled by defining ZERO_BIST_FAIL_CAPTURE_EN.
`timescale 1ns/1ps

module zero_bist #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       is_zero_in,
    output logic [7:0] n_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count
`ifdef ZERO_BIST_FAIL_CAPTURE_EN
    ,
    output logic [7:0] fail_pattern
`endif
);

    localparam logic [3:0] LAST_IDX    = 4'd12;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    function automatic logic [7:0] pattern_at(input logic [3:0] idx);
        logic [7:0] p;
        case (idx)
            4'd0:    p = 8'h01;
            4'd1:    p = 8'h02;
            4'd2:    p = 8'h04;
            4'd3:    p = 8'h08;
            4'd4:    p = 8'h10;
            4'd5:    p = 8'h20;
            4'd6:    p = 8'h40;
            4'd7:    p = 8'h80;
            4'd8:    p = 8'h00;
            4'd9:    p = 8'hAA;
            4'd10:   p = 8'h55;
            4'd11:   p = 8'hFF;
            default: p = 8'h00;
        endcase
        return p;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] settle_q, settle_d;
    logic [7:0] n_out_q, n_out_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] err_q, err_d;
    logic       mismatch;
`ifdef ZERO_BIST_FAIL_CAPTURE_EN
    logic [7:0] fail_q, fail_d;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        n_out_d  = n_out_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
`ifdef ZERO_BIST_FAIL_CAPTURE_EN
        fail_d   = fail_q;
`endif
        mismatch = is_zero_in != (pattern_at(idx_q) == 8'h00);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = DRIVE;
                    idx_d    = 4'd0;
                    settle_d = SETTLE_LOAD;
                    n_out_d  = pattern_at(4'd0);
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    err_d    = 4'd0;
`ifdef ZERO_BIST_FAIL_CAPTURE_EN
                    fail_d   = 8'h00;
`endif
                end
            end
            DRIVE: begin
                if (settle_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_d = sat_inc(err_q);
`ifdef ZERO_BIST_FAIL_CAPTURE_EN
                    // err_q is zero only before the first mismatch of this run
                    if (err_q == 4'd0) begin
                        fail_d = pattern_at(idx_q);
                    end
`endif
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    n_out_d = 8'h00;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 4'd0);
                end else begin
                    state_d  = DRIVE;
                    idx_d    = idx_q + 4'd1;
                    settle_d = SETTLE_LOAD;
                    n_out_d  = pattern_at(idx_q + 4'd1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            settle_q <= 4'd0;
            n_out_q  <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= 4'd0;
`ifdef ZERO_BIST_FAIL_CAPTURE_EN
            fail_q   <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            n_out_q  <= n_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
`ifdef ZERO_BIST_FAIL_CAPTURE_EN
            fail_q   <= fail_d;
`endif
        end
    end

    assign n_out     = n_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
`ifdef ZERO_BIST_FAIL_CAPTURE_EN
    assign fail_pattern = fail_q;
`endif

endmodule

// File: tb/tb_zero_bist.sv
// Self-checking bench for zero_bist: fixed detector scenarios from a vector table, randomized fault maps
// checked against a table-walk reference model, and reset corner sequences.
`timescale 1ns/1ps

module tb_zero_bist;

    localparam int S         = 2;
    localparam int PER       = S + 1;
    localparam int RUN_EDGES = 13 * PER + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       is_zero_in;
    logic [7:0] n_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [7:0] fail_pattern;

    int           mode;
    logic         noise;
    logic [255:0] fmap;
    int           n_checks = 0;
    int           n_fail   = 0;

    logic [7:0] tbl [13] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                             8'h80, 8'h00, 8'hAA, 8'h55, 8'hFF, 8'h00};

    typedef struct {
        int         mode;
        bit         extra;
        int         exp_err;
        bit         exp_pass;
        logic [7:0] exp_fp;
    } vec_t;

    zero_bist #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_zero_in (is_zero_in),
        .n_out      (n_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count)
`ifdef ZERO_BIST_FAIL_CAPTURE_EN
        ,
        .fail_pattern (fail_pattern)
`endif
    );

`ifndef ZERO_BIST_FAIL_CAPTURE_EN
    assign fail_pattern = 8'h00;
`endif

    always #5 clk = ~clk;

    // Detector under test: 0 correct, 1 stuck-0, 2 stuck-1, 3 inverted, 4 faulty per value via fmap
    function automatic logic det_out(input int m, input logic [7:0] v, input logic fbit);
        case (m)
            0:       return v == 8'h00;
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return v != 8'h00;
            default: return (v == 8'h00) ^ fbit;
        endcase
    endfunction

    always_comb is_zero_in = det_out(mode, n_out, fmap[n_out]) ^ noise;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk the pattern table, count mismatches (saturating), remember the first one
    task automatic model(input int m, output int e, output logic [7:0] fp);
        e  = 0;
        fp = 8'h00;
        for (int k = 0; k < 13; k++) begin
            if (det_out(m, tbl[k], fmap[tbl[k]]) != (tbl[k] == 8'h00)) begin
                if (e == 0) fp = tbl[k];
                e = (e < 15) ? e + 1 : 15;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " n_out"}, int'(n_out), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " pass"}, int'(pass), 0);
        chk({tag, " err_count"}, int'(err_count), 0);
        chk({tag, " fail_pattern"}, int'(fail_pattern), 0);
    endtask

    // Cycle numbering: the edge that samples start is cycle 1
    task automatic run_case(input string name, input int m, input bit extra, input bit glitch,
                            input int exp_err, input bit exp_pass, input logic [7:0] exp_fp);
        int done_cyc;
        int seq_bad;
        done_cyc = 0;
        seq_bad  = 0;
        mode     = m;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (done) begin
                done_cyc = c + 1;
                break;
            end
            if (c / PER < 13) begin
                if (busy !== 1'b1 || n_out !== tbl[c / PER]) seq_bad++;
            end else begin
                seq_bad++;
            end
            start = extra ? 1'($urandom_range(0, 1)) : 1'b0;
            noise = (glitch && ((c + 1) % PER != 0)) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        noise = 1'b0;
        chk({name, " done_cycle"}, done_cyc, RUN_EDGES);
        chk({name, " n_out_sequence_errors"}, seq_bad, 0);
        chk({name, " pass"}, int'(pass), int'(exp_pass));
        chk({name, " err_count"}, int'(err_count), exp_err);
        chk({name, " busy_at_done"}, int'(busy), 0);
`ifdef ZERO_BIST_FAIL_CAPTURE_EN
        chk({name, " fail_pattern"}, int'(fail_pattern), int'(exp_fp));
`endif
        @(negedge clk);
        chk({name, " done_held"}, int'(done), 1);
        chk({name, " n_out_idle"}, int'(n_out), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [5];
        int   e;
        logic [7:0] fp;

        vecs[0] = '{mode: 0, extra: 1'b0, exp_err: 0,  exp_pass: 1'b1, exp_fp: 8'h00};
        vecs[1] = '{mode: 1, extra: 1'b0, exp_err: 2,  exp_pass: 1'b0, exp_fp: 8'h00};
        vecs[2] = '{mode: 2, extra: 1'b0, exp_err: 11, exp_pass: 1'b0, exp_fp: 8'h01};
        vecs[3] = '{mode: 3, extra: 1'b1, exp_err: 13, exp_pass: 1'b0, exp_fp: 8'h01};
        vecs[4] = '{mode: 0, extra: 1'b1, exp_err: 0,  exp_pass: 1'b1, exp_fp: 8'h00};

        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        noise = 1'b0;
        fmap  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("por");

        // Reset wins over a simultaneous start and the start is not remembered
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_vs_start busy", int'(busy), 0);
        chk("rst_vs_start done", int'(done), 0);

        for (int i = 0; i < 5; i++) begin
            run_case($sformatf("vec%0d", i), vecs[i].mode, vecs[i].extra, 1'b0,
                     vecs[i].exp_err, vecs[i].exp_pass, vecs[i].exp_fp);
        end

        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 8; w++) fmap[w*32 +: 32] = $urandom;
            if (r == 0) fmap = '0;
            model(4, e, fp);
            run_case($sformatf("rand%0d", r), 4, 1'b1, 1'b1, e, (e == 0), fp);
        end
        fmap = '0;

        // Start on the first edge after reset release, then reset mid-run with errors accumulated
        @(negedge clk);
        rst  = 1'b1;
        mode = 3;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("first_start busy", int'(busy), 1);
        chk("first_start n_out", int'(n_out), 8'h01);
        repeat (18) @(negedge clk);
        chk("midrun errors_accumulated", int'(err_count != 4'd0), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("midrun_rst");
        repeat (3) @(negedge clk);
        chk("midrun_rst stays_idle", int'(busy), 0);
        run_case("after_rst", 0, 1'b0, 1'b0, 0, 1'b1, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
